// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI byte sequencer and its FIFOs.
package spi_pkg;

   localparam int unsigned SPI_DATA_W       = 8;
   localparam logic [7:0]  SPI_TIMEOUT_FILL = 8'hFF;

   typedef enum logic [1:0] {
      IDLE,
      LAUNCH,
      WAIT,
      STORE
   } spi_state_t;

endpackage

// File: rtl/spi_sync_fifo.sv
// Synchronous FIFO with extra-MSB pointers; rdata shows the head entry, or zero when empty.
module spi_sync_fifo
   import spi_pkg::*;
#(
   parameter int unsigned DATA_W = SPI_DATA_W,
   parameter int unsigned DEPTH  = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push,
   input  logic [DATA_W-1:0] wdata,
   input  logic              pop,
   output logic [DATA_W-1:0] rdata,
   output logic              full,
   output logic              empty
);

   localparam int unsigned AW      = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [AW:0]       wptr;
   logic [AW:0]       rptr;
   logic              do_push;
   logic              do_pop;

   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   always_ff @(posedge clk) begin
      if (rst) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         if (do_push) wptr <= wptr + PTR_ONE;
         if (do_pop)  rptr <= rptr + PTR_ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wptr[AW-1:0]] <= wdata;
   end

   assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
   assign empty = (wptr == rptr);
   assign rdata = empty ? '0 : mem[rptr[AW-1:0]];

endmodule

// File: rtl/spi_byte_sequencer.sv
// Feeds bytes from a TX FIFO to an SPI byte engine one at a time and queues replies in an RX FIFO.
// Optional transfer timeout with sticky err: define SPI_SEQ_TIMEOUT_EN.
module spi_byte_sequencer
   import spi_pkg::*;
#(
   parameter int unsigned DATA_W  = SPI_DATA_W,
   parameter int unsigned DEPTH   = 4
`ifdef SPI_SEQ_TIMEOUT_EN
   ,
   parameter int unsigned TIMEOUT = 64
`endif
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              in_ready,
   output logic [DATA_W-1:0] spi_din,
   output logic              spi_start,
   input  logic              spi_done,
   input  logic [DATA_W-1:0] spi_dout,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data,
   input  logic              out_ready,
   output logic              busy,
   output logic              err
);

   spi_state_t        state;
   logic [DATA_W-1:0] tx_head;
   logic [DATA_W-1:0] cap;
   logic              tx_full;
   logic              tx_empty;
   logic              rx_full;
   logic              rx_empty;

`ifdef SPI_SEQ_TIMEOUT_EN
   localparam int unsigned TW       = $clog2(TIMEOUT);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
   logic [TW-1:0] tmo_cnt;
`else
   assign err = 1'b0;
`endif

   assign in_ready  = !tx_full;
   assign out_valid = !rx_empty;
   assign busy      = (state != IDLE);

   spi_sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) tx_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (in_valid && !tx_full),
      .wdata (in_data),
      .pop   (state == LAUNCH),
      .rdata (tx_head),
      .full  (tx_full),
      .empty (tx_empty)
   );

   spi_sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) rx_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (state == STORE),
      .wdata (cap),
      .pop   (out_ready),
      .rdata (out_data),
      .full  (rx_full),
      .empty (rx_empty)
   );

   // spi_din is loaded on the IDLE->LAUNCH edge so it is already valid while spi_start
   // is high; the TX entry itself is retired at the end of LAUNCH.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         spi_start <= 1'b0;
         spi_din   <= '0;
         cap       <= '0;
`ifdef SPI_SEQ_TIMEOUT_EN
         tmo_cnt   <= '0;
         err       <= 1'b0;
`endif
      end else begin
         spi_start <= 1'b0;
         unique case (state)
            IDLE: begin
               if (!tx_empty && !rx_full) begin
                  state     <= LAUNCH;
                  spi_start <= 1'b1;
                  spi_din   <= tx_head;
               end
            end
            LAUNCH: begin
               state <= WAIT;
`ifdef SPI_SEQ_TIMEOUT_EN
               tmo_cnt <= '0;
`endif
            end
            WAIT: begin
               if (spi_done) begin
                  cap   <= spi_dout;
                  state <= STORE;
               end
`ifdef SPI_SEQ_TIMEOUT_EN
               else if (tmo_cnt == TMO_LAST) begin
                  cap   <= DATA_W'(SPI_TIMEOUT_FILL);
                  err   <= 1'b1;
                  state <= STORE;
               end else begin
                  tmo_cnt <= tmo_cnt + TW'(1);
               end
`endif
            end
            STORE: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_spi_byte_sequencer.sv
// Randomised bench for spi_byte_sequencer: queue-based reference model plus an SPI engine responder.
module tb_spi_byte_sequencer;

   localparam int unsigned DEPTH   = 4;
   localparam int unsigned TIMEOUT = 64;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic [7:0] in_data;
   logic       in_ready;
   logic [7:0] spi_din;
   logic       spi_start;
   logic       spi_done;
   logic [7:0] spi_dout;
   logic       out_valid;
   logic [7:0] out_data;
   logic       out_ready;
   logic       busy;
   logic       err;

   always #5 clk = ~clk;

   spi_byte_sequencer #(.DATA_W(8), .DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .spi_din   (spi_din),
      .spi_start (spi_start),
      .spi_done  (spi_done),
      .spi_dout  (spi_dout),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_ready (out_ready),
      .busy      (busy),
      .err       (err)
   );

   int unsigned checks   = 0;
   int unsigned failures = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   typedef struct {
      logic [7:0]  d;
      int unsigned vis;
   } rx_t;

   // Model state: bytes still to offer, bytes held in TX, replies owed downstream.
   logic [7:0]  src_q[$];
   logic [7:0]  tx_q[$];
   rx_t         rx_q[$];
   int unsigned start_cyc[$];
   int unsigned acc_cyc;
   bit          outstanding;
   bit          err_set;
   int unsigned err_at;
   int unsigned remain;
   int unsigned age;
   int unsigned cyc = 0;
   int unsigned outs;
   logic [7:0]  cur_din;

   // Knobs
   bit          hold;
   bit          spur;
   bit          gaps;
   int unsigned dout_mode;
   logic [7:0]  dout_fix;
   int unsigned dmin;
   int unsigned dmax;
   int unsigned rdy_pct;

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic step();
      logic exp_ov;
      rx_t  e;
      exp_ov = (rx_q.size() > 0) && (rx_q[0].vis <= cyc);
      check("in_ready", in_ready, tx_q.size() < DEPTH);
      check("out_valid", out_valid, exp_ov);
      check("err", err, err_set && (cyc >= err_at));

      spi_done = 1'b0;
      spi_dout = 8'($urandom);
      if (spi_start) begin
         check("start_allowed", !outstanding && (tx_q.size() > 0) && (rx_q.size() < DEPTH), 1);
         if (tx_q.size() > 0) check("spi_din", spi_din, tx_q.pop_front());
         outstanding = 1'b1;
         cur_din     = spi_din;
         remain      = $urandom_range(dmax, dmin);
         age         = 0;
         start_cyc.push_back(cyc);
      end else if (outstanding) begin
         check("busy_in_flight", busy, 1);
         check("din_held", spi_din, cur_din);
         age++;
         if (!hold) remain--;
         if (!hold && remain == 0) begin
            spi_done = 1'b1;
            spi_dout = (dout_mode == 1) ? cur_din : (dout_mode == 2) ? dout_fix : 8'($urandom);
            e.d   = spi_dout;
            e.vis = cyc + 2;
            rx_q.push_back(e);
            outstanding = 1'b0;
         end
`ifdef SPI_SEQ_TIMEOUT_EN
         else if (age == TIMEOUT) begin
            e.d   = 8'hFF;
            e.vis = cyc + 2;
            rx_q.push_back(e);
            outstanding = 1'b0;
            if (!err_set) begin
               err_set = 1'b1;
               err_at  = cyc + 1;
            end
         end
`endif
      end else if (spur && $urandom_range(15, 0) == 0) begin
         spi_done = 1'b1;
      end

      in_valid = (src_q.size() > 0) && (!gaps || $urandom_range(3, 0) != 0);
      in_data  = in_valid ? src_q[0] : 8'($urandom);
      if (in_valid && in_ready) begin
         tx_q.push_back(src_q.pop_front());
         acc_cyc = cyc;
      end

      out_ready = $urandom_range(99, 0) < rdy_pct;
      if (out_valid && out_ready && exp_ov) begin
         e = rx_q.pop_front();
         check("out_data", out_data, e.d);
         outs++;
      end
      tick();
   endtask

   task automatic drain(input int unsigned limit, input string tag);
      int unsigned n = 0;
      while ((src_q.size() > 0 || tx_q.size() > 0 || rx_q.size() > 0 || outstanding) && n < limit) begin
         step();
         n++;
      end
      check(tag, n < limit, 1);
   endtask

   task automatic do_reset();
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_data   = 8'h00;
      out_ready = 1'b0;
      spi_done  = 1'b0;
      spi_dout  = 8'h00;
      repeat (2) tick();
      rst = 1'b0;
      src_q.delete();
      tx_q.delete();
      rx_q.delete();
      start_cyc.delete();
      outstanding = 1'b0;
      err_set     = 1'b0;
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int unsigned n;
      hold = 0; spur = 0; gaps = 0; dout_mode = 0; dout_fix = 8'h00;
      dmin = 1; dmax = 1; rdy_pct = 100; outs = 0; acc_cyc = 0; err_at = 0;
      do_reset();
      check("rst_in_ready", in_ready, 1);
      check("rst_spi_start", spi_start, 0);
      check("rst_spi_din", spi_din, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_data", out_data, 0);
      check("rst_busy", busy, 0);
      check("rst_err", err, 0);

      // Single byte, reply CC after 16 cycles
      dmin = 16; dmax = 16; rdy_pct = 0; dout_mode = 2; dout_fix = 8'hCC;
      src_q.push_back(8'hAA);
      n = 0;
      while (start_cyc.size() == 0 && n < 20) begin step(); n++; end
      check("single_start_seen", start_cyc.size(), 1);
      check("accept_to_start", start_cyc[0] - acc_cyc, 2);
      n = 0;
      while (!out_valid && n < 40) begin step(); n++; end
      check("single_start_to_valid", cyc - start_cyc[0], 18);
      check("single_out_data", out_data, 8'hCC);
      check("single_busy_after", busy, 0);
      rdy_pct = 100;
      drain(20, "single_drain");

      // TX full with a stalled engine
      dout_mode = 0; dmin = 3; dmax = 3; hold = 1;
      start_cyc.delete();
      for (int i = 1; i <= 6; i++) src_q.push_back(8'(i));
      repeat (10) step();
      check("txfull_in_ready", in_ready, 0);
      check("txfull_pending", src_q.size(), 1);
      check("txfull_din", spi_din, 8'h01);
      hold = 0;
      drain(200, "txfull_drain");
      check("b2b_gap", start_cyc[2] - start_cyc[1], 6);

      // RX backpressure with echo replies
      rdy_pct = 0; dout_mode = 1; dmin = 2; dmax = 2;
      start_cyc.delete();
      for (int i = 0; i < 5; i++) src_q.push_back(8'h10 + 8'(i));
      repeat (60) step();
      check("rxbp_starts", start_cyc.size(), 4);
      check("rxbp_busy", busy, 0);
      check("rxbp_stored", rx_q.size(), 4);
      rdy_pct = 100;
      step();
      rdy_pct = 0;
      n = 0;
      while (start_cyc.size() < 5 && n < 20) begin step(); n++; end
      check("rxbp_fifth_start", start_cyc.size(), 5);
      rdy_pct = 100;
      drain(200, "rxbp_drain");

      // Reset while waiting on the engine, then a stale done
      hold = 1; dout_mode = 0;
      src_q.push_back(8'h5A);
      n = 0;
      while (!outstanding && n < 20) begin step(); n++; end
      repeat (3) step();
      check("midrst_busy_before", busy, 1);
      rst = 1'b1; in_valid = 1'b0;
      tick();
      rst = 1'b0;
      tx_q.delete(); rx_q.delete(); start_cyc.delete();
      outstanding = 1'b0; hold = 0;
      spi_done = 1'b1; spi_dout = 8'hA5;
      tick();
      spi_done = 1'b0;
      check("midrst_out_valid", out_valid, 0);
      check("midrst_in_ready", in_ready, 1);
      check("midrst_busy", busy, 0);
      repeat (4) step();
      check("midrst_no_start", start_cyc.size(), 0);

      // Spurious done while idle
      spi_done = 1'b1; spi_dout = 8'h77;
      tick();
      spi_done = 1'b0;
      check("spur_busy", busy, 0);
      check("spur_start", spi_start, 0);
      tick();
      check("spur_out_valid", out_valid, 0);
      check("spur_busy2", busy, 0);

      // Randomised traffic
      spur = 1; gaps = 1; dmin = 1; dmax = 8; rdy_pct = 60; outs = 0;
      for (int i = 0; i < 200; i++) src_q.push_back(8'($urandom));
      drain(20000, "random_drain");
      check("random_outs", outs, 200);

`ifdef SPI_SEQ_TIMEOUT_EN
      spur = 0; gaps = 0; rdy_pct = 100; hold = 1; dmin = 2; dmax = 2;
      start_cyc.delete();
      src_q.push_back(8'h31);
      src_q.push_back(8'h32);
      n = 0;
      while (start_cyc.size() < 2 && n < 300) begin
         step();
         if (err_set) hold = 0;
         n++;
      end
      check("tmo_second_start", start_cyc.size(), 2);
      drain(200, "tmo_drain");
      check("tmo_err_sticky", err, 1);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
